// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port SPI memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // The controller only handles byte, half-word and word transfers.
  function automatic logic size_legal(input logic [2:0] nbytes);
    case (nbytes)
      3'd1, 3'd2, 3'd4: size_legal = 1'b1;
      default:          size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: on a tie the port not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic pick
);

  // Winner selection from the two level requests
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = PORT_DBG;
    end else begin
      pick = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the external SPI memory controller,
// with a level-held start/done handshake and a transfer watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [2:0]        p0_nbytes,
  input  logic              p0_write,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p1_nbytes,
  input  logic              p1_write,
  input  logic [31:0]       p1_wdata,
  output logic              p0_done,
  output logic              p1_done,
  output logic              p0_err,
  output logic              p1_err,
  output logic [31:0]       rdata,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_nbytes,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              grant
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             WD_EN   = (TIMEOUT_CYCLES != 0);

  arb_state_e        state_r, next_state_s;
  logic              pick_valid_s, pick_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [2:0]        sel_nbytes_s;
  logic              sel_write_s, sel_legal_s;
  logic [31:0]       sel_wdata_s;
  logic              launch_s, reject_s, complete_s, abort_s;
  logic              finish_s, err_s, owner_s;
  logic [CNT_W-1:0]  cnt_r, cnt_inc_s;

  logic              mem_start_r, mem_write_r, busy_r, grant_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [2:0]        mem_nbytes_r;
  logic [31:0]       mem_wdata_r, rdata_r;
  logic              p0_done_r, p1_done_r, p0_err_r, p1_err_r;

  rr_pick2 u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_grant (grant_r),
    .valid      (pick_valid_s),
    .pick       (pick_s)
  );

  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Request fields of the winning port
  always_comb begin
    if (pick_s == PORT_DBG) begin
      sel_addr_s   = p1_addr;
      sel_nbytes_s = p1_nbytes;
      sel_write_s  = p1_write;
      sel_wdata_s  = p1_wdata;
    end else begin
      sel_addr_s   = p0_addr;
      sel_nbytes_s = p0_nbytes;
      sel_write_s  = p0_write;
      sel_wdata_s  = p0_wdata;
    end
    sel_legal_s = size_legal(sel_nbytes_s);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = launch_s ? BUSY : IDLE;
      BUSY:    next_state_s = (complete_s || abort_s) ? RELEASE : BUSY;
      RELEASE: next_state_s = mem_done ? RELEASE : IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Control strobes; a done sampled together with the watchdog limit counts as success
  always_comb begin
    launch_s   = 1'b0;
    reject_s   = 1'b0;
    complete_s = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s && sel_legal_s) begin
          launch_s = 1'b1;
        end else if (pick_valid_s) begin
          reject_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      BUSY: begin
        if (mem_done) begin
          complete_s = 1'b1;
        end else if (WD_EN && (cnt_inc_s == TO_VAL)) begin
          abort_s = 1'b1;
        end else begin
          abort_s = 1'b0;
        end
      end
      RELEASE: complete_s = 1'b0;
      default: launch_s = 1'b0;
    endcase
    finish_s = complete_s | abort_s | reject_s;
    err_s    = abort_s | reject_s;
    owner_s  = reject_s ? pick_s : grant_r;
  end

  // Datapath, handshake outputs and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_start_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_nbytes_r <= 3'd0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= 32'd0;
      rdata_r      <= 32'd0;
      p0_done_r    <= 1'b0;
      p1_done_r    <= 1'b0;
      p0_err_r     <= 1'b0;
      p1_err_r     <= 1'b0;
      busy_r       <= 1'b0;
      grant_r      <= PORT_DBG;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      p0_done_r <= finish_s && (owner_s == PORT_CPU);
      p1_done_r <= finish_s && (owner_s == PORT_DBG);
      p0_err_r  <= err_s && (owner_s == PORT_CPU);
      p1_err_r  <= err_s && (owner_s == PORT_DBG);
      busy_r    <= (next_state_s != IDLE);
      if (launch_s) begin
        mem_start_r  <= 1'b1;
        mem_addr_r   <= sel_addr_s;
        mem_nbytes_r <= sel_nbytes_s;
        mem_write_r  <= sel_write_s;
        mem_wdata_r  <= sel_wdata_s;
        grant_r      <= pick_s;
      end else if (reject_s) begin
        grant_r <= pick_s;
      end else if (complete_s || abort_s) begin
        mem_start_r <= 1'b0;
      end else begin
        mem_start_r <= mem_start_r;
      end
      if (complete_s && !mem_write_r) begin
        rdata_r <= mem_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
      if (state_r == BUSY) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign mem_start  = mem_start_r;
  assign mem_addr   = mem_addr_r;
  assign mem_nbytes = mem_nbytes_r;
  assign mem_write  = mem_write_r;
  assign mem_wdata  = mem_wdata_r;
  assign rdata      = rdata_r;
  assign p0_done    = p0_done_r;
  assign p1_done    = p1_done_r;
  assign p0_err     = p0_err_r;
  assign p1_err     = p1_err_r;
  assign busy       = busy_r;
  assign grant      = grant_r;

endmodule
